// File: rtl/ft601_mcfifo_pkg.sv
// Shared types and constants for the FT601 multi-channel FIFO transmit path.
// Word geometry, channel-index width and the drain-engine state encoding.
package ft601_mcfifo_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int MAX_CH         = 4;
  localparam int CH_W           = 2;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    BURST,
    DRAIN,
    GAP
  } state_t;

  // Cyclic successor of a channel index within num_ch channels.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch, input int num_ch);
    return (int'(ch) == num_ch - 1) ? '0 : ch + 1'b1;
  endfunction

endpackage

// File: rtl/ft601_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or after rr_ptr,
// searched cyclically. Returns a one-hot grant and the matching index.
module ft601_rr_arbiter
  import ft601_mcfifo_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CH_W-1:0]   rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   grant_idx
);

  int c;

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    c         = 0;
    // Walk from farthest to nearest so the closest requester overwrites the rest.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      c = (int'(rr_ptr) + k) % NUM_CH;
      if (req[c]) begin
        grant     = '0;
        grant[c]  = 1'b1;
        grant_idx = CH_W'(c);
      end
    end
  end

endmodule

// File: rtl/ft601_mcfifo_tx_engine.sv
// FT601-side drain engine: round-robin grants one wr_buf channel, pops a whole packet
// through its FWFT port and presents it on the FT601 write bus via one output register.
module ft601_mcfifo_tx_engine
  import ft601_mcfifo_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                       rd_clk,
  input  logic                       rd_reset_n,
  input  logic [NUM_CH-1:0]          rd_xfer_req,
  input  logic [NUM_CH-1:0]          rd_valid,
  input  logic [WORD_W*NUM_CH-1:0]   rd_data,
  input  logic [BYTES_PER_WORD*NUM_CH-1:0] rd_be,
  output logic [NUM_CH-1:0]          rd_en,
  input  logic                       ft_txe_n,
  output logic                       ft_wr_n,
  output logic [WORD_W-1:0]          ft_data,
  output logic [BYTES_PER_WORD-1:0]  ft_be,
  output logic [CH_W-1:0]            ft_ch,
  output logic                       busy,
  output logic [31:0]                pkt_count
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  state_t            state;
  logic [CH_W-1:0]   g;
  logic [CH_W-1:0]   rr_ptr;
  logic [GAP_W-1:0]  gap_cnt;
  logic [NUM_CH-1:0] arb_grant;
  logic [CH_W-1:0]   arb_idx;
  logic              g_req;
  logic              g_valid;
  logic              accepted;
  logic              load;

  ft601_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req       (rd_xfer_req),
    .rr_ptr    (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  assign g_req    = rd_xfer_req[g];
  assign g_valid  = rd_valid[g];
  assign accepted = !ft_wr_n && !ft_txe_n;
  // The output register may be refilled when empty or when its word leaves this edge.
  assign load     = (state == BURST) && g_req && g_valid && (ft_wr_n || !ft_txe_n);

  always_comb begin
    rd_en    = '0;
    rd_en[g] = load;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge rd_clk or negedge rd_reset_n) begin
    if (!rd_reset_n) begin
      state     <= IDLE;
      g         <= '0;
      rr_ptr    <= '0;
      gap_cnt   <= '0;
      ft_wr_n   <= 1'b1;
      ft_data   <= '0;
      ft_be     <= '0;
      ft_ch     <= '0;
      busy      <= 1'b0;
      pkt_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|arb_grant) begin
            g     <= arb_idx;
            ft_ch <= arb_idx;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          state <= g_req ? BURST : DRAIN;
        end
        BURST: begin
          if (load) begin
            ft_data <= rd_data[int'(g)*WORD_W +: WORD_W];
            ft_be   <= rd_be[int'(g)*BYTES_PER_WORD +: BYTES_PER_WORD];
            ft_wr_n <= 1'b0;
          end else if (accepted) begin
            ft_wr_n <= 1'b1;
          end
          if (!g_req) state <= DRAIN;
        end
        DRAIN: begin
          // Wait for any word still parked in the output register to be taken.
          if (ft_wr_n || !ft_txe_n) begin
            ft_wr_n   <= 1'b1;
            pkt_count <= pkt_count + 32'd1;
            rr_ptr    <= next_ch(g, NUM_CH);
            gap_cnt   <= '0;
            state     <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft601_mcfifo_tx_engine.sv
// Directed bench for ft601_mcfifo_tx_engine: a small per-channel wr_buf model feeds
// the FWFT ports, every accepted FT601 word is logged and compared with hand-built packets.
module tb_ft601_mcfifo_tx_engine;

  logic         rd_clk = 1'b0;
  logic         rd_reset_n;
  logic [3:0]   rd_xfer_req;
  logic [3:0]   rd_valid;
  logic [127:0] rd_data;
  logic [15:0]  rd_be;
  logic [3:0]   rd_en;
  logic         ft_txe_n;
  logic         ft_wr_n;
  logic [31:0]  ft_data;
  logic [3:0]   ft_be;
  logic [1:0]   ft_ch;
  logic         busy;
  logic [31:0]  pkt_count;

  ft601_mcfifo_tx_engine #(.NUM_CH(4), .GAP_CYCLES(2)) dut (
    .rd_clk      (rd_clk),
    .rd_reset_n  (rd_reset_n),
    .rd_xfer_req (rd_xfer_req),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .rd_be       (rd_be),
    .rd_en       (rd_en),
    .ft_txe_n    (ft_txe_n),
    .ft_wr_n     (ft_wr_n),
    .ft_data     (ft_data),
    .ft_be       (ft_be),
    .ft_ch       (ft_ch),
    .busy        (busy),
    .pkt_count   (pkt_count)
  );

  always #5 rd_clk = ~rd_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // wr_buf model
  logic [31:0] mdata [4][32];
  logic [3:0]  mbe   [4][32];
  int          head  [4];
  int          tail  [4];
  bit          pkt_on [4];
  bit          vblock [4];
  bit          req_only [4];

  // accepted-word log and per-cycle observations
  logic [31:0] log_d  [$];
  logic [3:0]  log_be [$];
  logic [1:0]  log_ch [$];
  logic [3:0]  last_pop;
  int cyc = 0, first_low = -1, last_low = -1, low_cnt = 0;
  int cnt_wr_hi = 0, bad_rden = 0, stall_pops = 0;

  task automatic drive();
    for (int c = 0; c < 4; c++) begin
      logic pend;
      pend = pkt_on[c] && (head[c] < tail[c]);
      rd_xfer_req[c]     = pend || req_only[c];
      rd_valid[c]        = pend && !vblock[c];
      rd_data[32*c +: 32] = pend ? mdata[c][head[c]] : 32'h0;
      rd_be[4*c +: 4]     = pend ? mbe[c][head[c]] : 4'h0;
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < 4; c++) begin
      pkt_on[c] = 0; vblock[c] = 0; req_only[c] = 0; head[c] = 0; tail[c] = 0;
    end
    drive();
  endtask

  task automatic load_pkt(input int ch, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      mdata[ch][i] = base + 32'(i);
      mbe[ch][i]   = (i == n - 1) ? 4'h3 : 4'hF;
    end
    head[ch] = 0; tail[ch] = n; pkt_on[ch] = 1;
    drive();
  endtask

  // One clock: observe at the falling edge, update the wr_buf model just after the rising edge.
  task automatic cycle();
    @(negedge rd_clk);
    last_pop = rd_en;
    if ((rd_en & ~(4'b0001 << ft_ch)) !== 4'b0000) bad_rden++;
    if (ft_wr_n === 1'b1) cnt_wr_hi++;
    else begin
      if (first_low < 0) first_low = cyc;
      last_low = cyc;
      low_cnt++;
    end
    if (ft_wr_n === 1'b0 && ft_txe_n === 1'b0) begin
      log_d.push_back(ft_data); log_be.push_back(ft_be); log_ch.push_back(ft_ch);
    end
    if (ft_txe_n === 1'b1 && rd_en !== 4'b0000) stall_pops++;
    cyc++;
    @(posedge rd_clk); #1;
    for (int c = 0; c < 4; c++) if (last_pop[c]) head[c]++;
    drive();
  endtask

  task automatic wait_pkts(input logic [31:0] target, input string tag);
    int n = 0;
    while (pkt_count !== target && n < 300) begin cycle(); n++; end
    n_cmp++;
    if (pkt_count !== target) begin
      n_bad++; $display("FAIL %s_pkt_timeout: pkt_count=%0d want %0d", tag, pkt_count, target);
    end
    repeat (4) cycle();
  endtask

  task automatic test_reset();
    int seen = 0;
    rd_reset_n = 1'b0;
    load_pkt(0, 4, 32'h1111_0000);
    load_pkt(1, 4, 32'h2222_0000);
    repeat (4) begin
      @(negedge rd_clk);
      if (rd_en !== 4'b0000) seen++;
    end
    n_cmp++; if (seen !== 0)        begin n_bad++; $display("FAIL reset_rd_en: got %0d pops want 0", seen); end
    n_cmp++; if (ft_wr_n !== 1'b1)  begin n_bad++; $display("FAIL reset_ft_wr_n: got %b want 1", ft_wr_n); end
    n_cmp++; if (ft_data !== 32'h0) begin n_bad++; $display("FAIL reset_ft_data: got %h want 0", ft_data); end
    n_cmp++; if (ft_be !== 4'h0)    begin n_bad++; $display("FAIL reset_ft_be: got %h want 0", ft_be); end
    n_cmp++; if (ft_ch !== 2'd0)    begin n_bad++; $display("FAIL reset_ft_ch: got %0d want 0", ft_ch); end
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (pkt_count !== 32'd0) begin n_bad++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
    clear_model();
    @(negedge rd_clk); rd_reset_n = 1'b1;
    repeat (2) cycle();
    n_cmp++; if (busy !== 1'b0)     begin n_bad++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_burst();
    int ix = log_d.size();
    first_low = -1; last_low = -1; low_cnt = 0; bad_rden = 0;
    ft_txe_n = 1'b0;
    load_pkt(1, 16, 32'hC100_0000);
    wait_pkts(32'd1, "burst");
    n_cmp++; if (log_d.size() !== ix + 16) begin n_bad++; $display("FAIL burst_words: got %0d want 16", log_d.size() - ix); end
    for (int k = 0; k < 16 && ix + k < log_d.size(); k++) begin
      n_cmp++;
      if ({log_ch[ix+k], log_d[ix+k], log_be[ix+k]} !== {2'd1, 32'hC100_0000 + 32'(k), (k == 15) ? 4'h3 : 4'hF}) begin
        n_bad++; $display("FAIL burst_word%0d: got ch%0d %h/%h want ch1 %h", k, log_ch[ix+k], log_d[ix+k], log_be[ix+k], 32'hC100_0000 + 32'(k));
      end
    end
    n_cmp++; if (low_cnt !== 16) begin n_bad++; $display("FAIL burst_wr_low_cycles: got %0d want 16", low_cnt); end
    n_cmp++; if (last_low - first_low !== 15) begin n_bad++; $display("FAIL burst_contiguous: span %0d want 15", last_low - first_low); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL burst_busy_after: got %b want 0", busy); end
    n_cmp++; if (bad_rden !== 0) begin n_bad++; $display("FAIL burst_rd_en_other: got %0d want 0", bad_rden); end
  endtask

  task automatic test_stall();
    int ix = log_d.size();
    int n = 0, held = 0;
    load_pkt(0, 8, 32'hA000_0000);
    while (!(ft_wr_n === 1'b0 && ft_data === 32'hA000_0002) && n < 40) begin cycle(); n++; end
    n_cmp++; if (ft_data !== 32'hA000_0002) begin n_bad++; $display("FAIL stall_word3_seen: got %h want a0000002", ft_data); end
    ft_txe_n = 1'b1; stall_pops = 0;
    repeat (5) begin
      cycle();
      if (ft_wr_n === 1'b0 && ft_data === 32'hA000_0002 && ft_be === 4'hF) held++;
    end
    n_cmp++; if (held !== 5) begin n_bad++; $display("FAIL stall_hold: held %0d cycles want 5", held); end
    n_cmp++; if (stall_pops !== 0) begin n_bad++; $display("FAIL stall_pop: got %0d pops want 0", stall_pops); end
    ft_txe_n = 1'b0;
    wait_pkts(32'd2, "stall");
    n_cmp++; if (log_d.size() !== ix + 8) begin n_bad++; $display("FAIL stall_words: got %0d want 8", log_d.size() - ix); end
    for (int k = 0; k < 8 && ix + k < log_d.size(); k++) begin
      n_cmp++;
      if ({log_ch[ix+k], log_d[ix+k]} !== {2'd0, 32'hA000_0000 + 32'(k)}) begin
        n_bad++; $display("FAIL stall_word%0d: got ch%0d %h want ch0 %h", k, log_ch[ix+k], log_d[ix+k], 32'hA000_0000 + 32'(k));
      end
    end
  endtask

  task automatic test_round_robin();
    int ix, n = 0;
    bit reloaded = 0;
    logic [1:0]  ech;
    logic [31:0] ed;
    rd_reset_n = 1'b0; clear_model();
    @(negedge rd_clk); rd_reset_n = 1'b1;
    cycle();
    ix = log_d.size();
    load_pkt(0, 4, 32'h00A0_0000);
    load_pkt(2, 4, 32'h02A0_0000);
    while (pkt_count !== 32'd3 && n < 400) begin
      cycle(); n++;
      if (!reloaded && pkt_count === 32'd1) begin load_pkt(0, 3, 32'h00B0_0000); reloaded = 1; end
    end
    repeat (4) cycle();
    n_cmp++; if (pkt_count !== 32'd3) begin n_bad++; $display("FAIL rr_pkt_count: got %0d want 3", pkt_count); end
    n_cmp++; if (log_d.size() !== ix + 11) begin n_bad++; $display("FAIL rr_words: got %0d want 11", log_d.size() - ix); end
    for (int k = 0; k < 11 && ix + k < log_d.size(); k++) begin
      if (k < 4)      begin ech = 2'd0; ed = 32'h00A0_0000 + 32'(k);     end
      else if (k < 8) begin ech = 2'd2; ed = 32'h02A0_0000 + 32'(k - 4); end
      else            begin ech = 2'd0; ed = 32'h00B0_0000 + 32'(k - 8); end
      n_cmp++;
      if ({log_ch[ix+k], log_d[ix+k]} !== {ech, ed}) begin
        n_bad++; $display("FAIL rr_order%0d: got ch%0d %h want ch%0d %h", k, log_ch[ix+k], log_d[ix+k], ech, ed);
      end
    end
  endtask

  task automatic test_bubble();
    int ix = log_d.size();
    int n = 0, hi0, ch_bad = 0;
    bad_rden = 0;
    load_pkt(3, 6, 32'h0D00_0000);
    while (log_d.size() < ix + 2 && n < 40) begin cycle(); n++; end
    vblock[3] = 1;
    load_pkt(1, 2, 32'h0B00_0000);
    hi0 = cnt_wr_hi;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) begin vblock[3] = 0; drive(); end
      cycle();
      if (ft_ch !== 2'd3) ch_bad++;
    end
    n_cmp++; if (cnt_wr_hi - hi0 !== 3) begin n_bad++; $display("FAIL bubble_wr_high: got %0d cycles want 3", cnt_wr_hi - hi0); end
    n_cmp++; if (ch_bad !== 0) begin n_bad++; $display("FAIL bubble_ft_ch: %0d cycles off ch3 want 0", ch_bad); end
    wait_pkts(32'd5, "bubble");
    n_cmp++; if (log_d.size() !== ix + 8) begin n_bad++; $display("FAIL bubble_words: got %0d want 8", log_d.size() - ix); end
    for (int k = 0; k < 8 && ix + k < log_d.size(); k++) begin
      n_cmp++;
      if ({log_ch[ix+k], log_d[ix+k]} !== ((k < 6) ? {2'd3, 32'h0D00_0000 + 32'(k)} : {2'd1, 32'h0B00_0000 + 32'(k - 6)})) begin
        n_bad++; $display("FAIL bubble_order%0d: got ch%0d %h", k, log_ch[ix+k], log_d[ix+k]);
      end
    end
    n_cmp++; if (bad_rden !== 0) begin n_bad++; $display("FAIL bubble_rd_en_other: got %0d want 0", bad_rden); end
  endtask

  task automatic test_grant_drop();
    int ix = log_d.size();
    req_only[2] = 1; drive();
    cycle();
    n_cmp++; if ({busy, ft_ch} !== {1'b1, 2'd2}) begin n_bad++; $display("FAIL drop_grant: got busy=%b ch%0d want busy=1 ch2", busy, ft_ch); end
    req_only[2] = 0; drive();
    wait_pkts(32'd6, "drop");
    n_cmp++; if (log_d.size() !== ix) begin n_bad++; $display("FAIL drop_words: got %0d want 0", log_d.size() - ix); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL drop_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_burst();
    int ix = log_d.size();
    int n = 0;
    n_cmp++; if (pkt_count !== 32'd6) begin n_bad++; $display("FAIL midrst_pre_count: got %0d want 6", pkt_count); end
    load_pkt(2, 10, 32'h0C00_0000);
    while (log_d.size() < ix + 4 && n < 40) begin cycle(); n++; end
    n_cmp++; if ({ft_wr_n, ft_data} !== {1'b0, 32'h0C00_0004}) begin n_bad++; $display("FAIL midrst_word5: got wr_n=%b %h want 0 0c000004", ft_wr_n, ft_data); end
    #2 rd_reset_n = 1'b0;
    #1;
    n_cmp++; if (ft_wr_n !== 1'b1)    begin n_bad++; $display("FAIL midrst_ft_wr_n: got %b want 1", ft_wr_n); end
    n_cmp++; if (ft_data !== 32'h0)   begin n_bad++; $display("FAIL midrst_ft_data: got %h want 0", ft_data); end
    n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (pkt_count !== 32'd0) begin n_bad++; $display("FAIL midrst_pkt_count: got %0d want 0", pkt_count); end
    n_cmp++; if (rd_en !== 4'b0000)   begin n_bad++; $display("FAIL midrst_rd_en: got %b want 0000", rd_en); end
    n_cmp++; if (ft_ch !== 2'd0)      begin n_bad++; $display("FAIL midrst_ft_ch: got %0d want 0", ft_ch); end
    clear_model();
    @(negedge rd_clk); rd_reset_n = 1'b1;
    repeat (3) cycle();
    n_cmp++; if ({busy, ft_wr_n} !== 2'b01) begin n_bad++; $display("FAIL midrst_after: got busy=%b wr_n=%b want 0 1", busy, ft_wr_n); end
  endtask

  initial begin
    rd_reset_n  = 1'b0;
    ft_txe_n    = 1'b0;
    last_pop    = 4'b0;
    rd_xfer_req = '0; rd_valid = '0; rd_data = '0; rd_be = '0;
    clear_model();
    test_reset();
    test_single_burst();
    test_stall();
    test_round_robin();
    test_bubble();
    test_grant_drop();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
